ifu_fetch: RTL and testbench
============================

# ifu_fetch

Instruction-fetch unit for the five-stage MIPS pipeline. It owns the fetch PC, issues requests to instruction memory over a request/grant, in-order-response interface, and buffers returned words. It hands (pcIF, instrIF) to ID through a valid/ready handshake. It consumes the redirect decisions produced by next-PC logic in ID while preserving exactly one branch-delay-slot instruction per redirect.

## Interface
- RESET_PC, 32'h0000_3000: fetch PC after reset.
- DEPTH, 2: combined limit on outstanding requests plus buffered words. Range 2..4.

Ports:
- clk, input, 1: single clock, rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- redirect_valid, input, 1: ID resolved a taken branch or jump this cycle.
- redirect_pc, input, 32: target address; bits [1:0] are always 0.
- imem_req, output, 1: fetch request valid.
- imem_addr, output, 32: word address of the request.
- imem_gnt, input, 1: request accepted this cycle.
- imem_rvalid, input, 1: response word valid. Responses return in order, at least 1 cycle after grant.
- imem_rdata, input, 32: instruction word.
- id_valid, output, 1: buffer head is available to ID.
- id_pc, output, 32: PC of the head word.
- id_instr, output, 32: head instruction word.
- id_ready, input, 1: ID accepts the head this cycle.

## Operation
State:
- fetch_pc
- pcq: a FIFO of PCs for outstanding requests, depth DEPTH
- ibuf: a FIFO of (pc, instr) pairs, depth DEPTH
- out_cnt, buf_cnt
- drop_cnt
- keep_next flag
- pend_valid and pend_pc, for a deferred target

Signals:
- pop = id_valid && id_ready.
- issue = imem_req && imem_gnt. On issue: push fetch_pc into pcq, out_cnt+1, fetch_pc+4 (32-bit wrap, no overflow flag).
- imem_req = !redirect_valid && (out_cnt + buf_cnt - pop) < DEPTH. imem_addr = fetch_pc.
- Response handling (imem_rvalid):
  - Pop pcq and decrement out_cnt.
  - If drop_cnt > 0, discard the word and decrement drop_cnt.
  - Otherwise push (pc, rdata) into ibuf.
  - When keep_next is set, the kept word clears keep_next, and all later in-flight words are dropped through drop_cnt.
- id_valid = buf_cnt > 0. id_pc and id_instr come combinationally from the ibuf head.
- Redirect (redirect_valid=1) keeps exactly one delay-slot instruction, chosen by the first matching case:
  1. pop this cycle: the popped word is the delay slot.
     - Clear ibuf.
     - drop_cnt = out_cnt - rvalid.
     - fetch_pc = redirect_pc.
  2. buf_cnt > 0: keep only the ibuf head and discard the other entries.
     - drop_cnt = out_cnt - rvalid.
     - fetch_pc = redirect_pc.
  3. rvalid (and no drop pending): keep that response.
     - drop_cnt = out_cnt - 1.
     - fetch_pc = redirect_pc.
  4. out_cnt > 0: keep the next response.
     - keep_next = 1 and drop_cnt = out_cnt - 1.
     - fetch_pc = redirect_pc.
  5. Nothing in flight: the delay slot has not been fetched yet.
     - fetch_pc is unchanged (it already points at the slot).
     - pend_valid = 1 and pend_pc = redirect_pc.
     - When the slot request is granted, fetch_pc = pend_pc instead of +4, and pend_valid clears.
- ID never asserts redirect_valid on consecutive cycles. Behaviour for a second redirect while pend_valid=1 or keep_next=1 is unspecified; the bench flags it with an assertion.

## Timing
- Reset (async assert) drives the following; imem restarts with the core.
  - fetch_pc=RESET_PC
  - all counters=0
  - keep_next=0, pend_valid=0
  - imem_req=0 while reset_n is low
  - id_valid=0, id_pc=0, id_instr=0
- First imem_req is in the first cycle after reset_n deasserts.
- Latency: grant in cycle t with rvalid in t+1 gives id_valid in t+2. There is no rdata bypass to ID.
- Throughput: 1 instruction/cycle with 1-cycle memory, DEPTH=2, and id_ready held high. The credit check counts a same-cycle pop.
- Full: out_cnt+buf_cnt=DEPTH with no pop forces imem_req=0.
- Empty: id_valid=0, and id_pc/id_instr hold their last values.
- imem_req is deasserted in the redirect cycle. The first request to the target is in the next cycle, or after the slot grant in case 5.
- Redirect and a response in the same cycle are resolved by the case order above.
- Reset mid-operation discards everything with no drain.

## Test plan
- Reset then 1-cycle memory with id_ready=1: request addresses 0x3000, 0x3004, 0x3008 on consecutive cycles. id_pc sequence is 0x3000, 0x3004, … with one instruction per cycle from cycle 2.
- id_ready=0 for 5 cycles: at most DEPTH=2 words buffered and imem_req=0 while full. Release delivers 0x3000, 0x3004 in order with no duplicates.
- Redirect to 0x3100 while the head at 0x3008 is popped the same cycle and 0x300C is in flight: 0x300C is dropped, and the next id_pc is 0x3100.
- Redirect to 0x3200 with buf_cnt=2 (0x3004, 0x3008) and no pop: id_pc shows 0x3004, then 0x3200. 0x3008 is never shown.
- Memory grant stalled so nothing is in flight, then redirect to 0x3400 with fetch_pc=0x3010: the next request is 0x3010, then 0x3400. ID sees 0x3010 then 0x3400.
- Assert reset_n=0 mid-stream with 2 in flight: all outputs are at reset values immediately, and the first request after release is 0x3000.

Source files
------------

// File: rtl/ifu_fetch.sv
// Instruction-fetch unit: owns the fetch PC, issues imem requests under a credit
// limit, buffers returned words for ID and keeps exactly one delay slot per redirect.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    input  logic        id_ready
);
    localparam logic [2:0] DEPTH_C = 3'(DEPTH);
    localparam logic [3:0] DEPTH_W = 4'(DEPTH);

    logic [31:0] pcq        [4];
    logic [31:0] ibuf_pc    [4];
    logic [31:0] ibuf_instr [4];
    logic [1:0]  q_head, b_head;
    logic [2:0]  out_cnt, buf_cnt, drop_cnt;
    logic [31:0] fetch_pc, pend_pc, hold_pc, hold_instr;
    logic        keep_next, pend_valid;

    logic        pop, issue, push, buf_clear, buf_trim;
    logic [3:0]  credit;
    logic [2:0]  drop_nxt;
    logic [31:0] fetch_pc_nxt, pend_pc_nxt;
    logic        keep_nxt, pend_valid_nxt;

    function automatic logic [1:0] wrap_add(input logic [1:0] a, input logic [2:0] b);
        logic [2:0] s;
        s = {1'b0, a} + b;
        if (s >= DEPTH_C) s = s - DEPTH_C;
        return s[1:0];
    endfunction

    // The credit check counts a same-cycle pop so a 1-cycle memory sustains full rate.
    assign pop       = (buf_cnt != 3'd0) && id_ready;
    assign credit    = {1'b0, out_cnt} + {1'b0, buf_cnt} - {3'b000, pop};
    assign imem_req  = reset_n && !redirect_valid && (credit < DEPTH_W);
    assign imem_addr = fetch_pc;
    assign issue     = imem_req && imem_gnt;
    assign id_valid  = (buf_cnt != 3'd0);
    assign id_pc     = id_valid ? ibuf_pc[b_head]    : hold_pc;
    assign id_instr  = id_valid ? ibuf_instr[b_head] : hold_instr;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        push           = 1'b0;
        buf_clear      = 1'b0;
        buf_trim       = 1'b0;
        drop_nxt       = drop_cnt;
        keep_nxt       = keep_next;
        pend_valid_nxt = pend_valid;
        pend_pc_nxt    = pend_pc;
        fetch_pc_nxt   = fetch_pc;

        if (imem_rvalid) begin
            if (keep_next) begin
                push     = 1'b1;
                keep_nxt = 1'b0;
            end else if (drop_cnt != 3'd0) begin
                drop_nxt = drop_cnt - 3'd1;
            end else begin
                push = 1'b1;
            end
        end

        if (issue) begin
            if (pend_valid) begin
                fetch_pc_nxt   = pend_pc;
                pend_valid_nxt = 1'b0;
            end else begin
                fetch_pc_nxt = fetch_pc + 32'd4;
            end
        end

        // Delay-slot selection: first matching case wins.
        if (redirect_valid) begin
            if (pop) begin
                buf_clear    = 1'b1;
                push         = 1'b0;
                drop_nxt     = out_cnt - 3'(imem_rvalid);
                fetch_pc_nxt = redirect_pc;
            end else if (buf_cnt != 3'd0) begin
                buf_trim     = 1'b1;
                push         = 1'b0;
                drop_nxt     = out_cnt - 3'(imem_rvalid);
                fetch_pc_nxt = redirect_pc;
            end else if (imem_rvalid && (drop_cnt == 3'd0)) begin
                push         = 1'b1;
                drop_nxt     = out_cnt - 3'd1;
                fetch_pc_nxt = redirect_pc;
            end else if (out_cnt != 3'd0) begin
                keep_nxt     = 1'b1;
                drop_nxt     = out_cnt - 3'd1;
                fetch_pc_nxt = redirect_pc;
            end else begin
                pend_valid_nxt = 1'b1;
                pend_pc_nxt    = redirect_pc;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc   <= RESET_PC;
            out_cnt    <= 3'd0;
            buf_cnt    <= 3'd0;
            drop_cnt   <= 3'd0;
            q_head     <= 2'd0;
            b_head     <= 2'd0;
            keep_next  <= 1'b0;
            pend_valid <= 1'b0;
            pend_pc    <= 32'd0;
            hold_pc    <= 32'd0;
            hold_instr <= 32'd0;
        end else begin
            fetch_pc   <= fetch_pc_nxt;
            drop_cnt   <= drop_nxt;
            keep_next  <= keep_nxt;
            pend_valid <= pend_valid_nxt;
            pend_pc    <= pend_pc_nxt;
            out_cnt    <= out_cnt + 3'(issue) - 3'(imem_rvalid);
            if (imem_rvalid) q_head <= wrap_add(q_head, 3'd1);
            if (buf_clear)     buf_cnt <= 3'd0;
            else if (buf_trim) buf_cnt <= 3'd1;
            else               buf_cnt <= buf_cnt + 3'(push) - 3'(pop);
            if (pop && !buf_clear) b_head <= wrap_add(b_head, 3'd1);
            if (id_valid) begin
                hold_pc    <= id_pc;
                hold_instr <= id_instr;
            end
        end
    end

    // NOTE: FIFO storage is not reset; the counters alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (issue) pcq[wrap_add(q_head, out_cnt)] <= fetch_pc;
        if (push) begin
            ibuf_pc[wrap_add(b_head, buf_cnt)]    <= pcq[q_head];
            ibuf_instr[wrap_add(b_head, buf_cnt)] <= imem_rdata;
        end
    end
endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: an in-order memory model plus scoreboards of
// expected request addresses and expected (pc, instr) deliveries to ID.
module tb_ifu_fetch;
    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        id_ready = 1'b0;

    int          n_checks = 0;
    int          n_fail = 0;
    logic        resp_en = 1'b1;
    logic        prev_redirect = 1'b0;
    logic [31:0] mem_q   [$];
    logic [31:0] exp_q   [$];
    logic [31:0] exp_req [$];

    ifu_fetch #(.RESET_PC(32'h0000_3000), .DEPTH(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr), .id_ready(id_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset_n) begin
            assert (!(redirect_valid && (prev_redirect || dut.pend_valid || dut.keep_next)))
                else $error("illegal redirect while a previous one is unresolved");
        end
        prev_redirect <= redirect_valid;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic push_seq(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
    endtask

    task automatic drained(input string tag);
        check({tag, "_pc_sb"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_req_sb"}, 32'(exp_req.size()), 32'd0);
    endtask

    // One cycle: observe handshakes, cross the edge, drive the memory response.
    task automatic tick();
        logic [31:0] e;
        #1;
        if (imem_req && imem_gnt) begin
            mem_q.push_back(imem_addr);
            if (exp_req.size() > 0) check("req_addr", imem_addr, exp_req.pop_front());
        end
        if (id_valid && id_ready) begin
            if (exp_q.size() == 0) begin
                check("pop_expected", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("id_pc", id_pc, e);
                check("id_instr", id_instr, mem_word(e));
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (resp_en && mem_q.size() > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mem_q.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'd0;
        end
    endtask

    task automatic reset_dut(input string tag);
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        id_ready       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'd0;
        resp_en        = 1'b1;
        imem_gnt       = 1'b1;
        #1;
        check({tag, "_req"}, 32'(imem_req), 32'd0);
        check({tag, "_valid"}, 32'(id_valid), 32'd0);
        check({tag, "_pc"}, id_pc, 32'd0);
        check({tag, "_instr"}, id_instr, 32'd0);
        mem_q.delete();
        exp_q.delete();
        exp_req.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        // Streaming at full rate.
        reset_dut("rst0");
        id_ready = 1'b1;
        push_seq(32'h3000, 6);
        exp_req = '{32'h3000, 32'h3004, 32'h3008};
        for (int c = 0; c < 8; c++) begin
            #1;
            if (c == 0) check("s1_first_req", 32'(imem_req), 32'd1);
            check("s1_valid", 32'(id_valid), 32'(c >= 2));
            tick();
        end
        drained("s1");

        // Back-pressure fills the buffer, then release.
        reset_dut("rst1");
        push_seq(32'h3000, 6);
        exp_req = '{32'h3000, 32'h3004, 32'h3008};
        for (int c = 0; c < 11; c++) begin
            id_ready = (c >= 5);
            #1;
            if (c >= 2 && c <= 4) check("s2_full_req", 32'(imem_req), 32'd0);
            if (c == 3) check("s2_head", id_pc, 32'h3000);
            tick();
        end
        drained("s2");

        // Redirect while the head is popped: in-flight 0x300C dropped.
        reset_dut("rst2");
        id_ready = 1'b1;
        redirect_pc = 32'h3100;
        push_seq(32'h3000, 3);
        push_seq(32'h3100, 4);
        exp_req = '{32'h3000, 32'h3004, 32'h3008, 32'h300C, 32'h3100, 32'h3104};
        for (int c = 0; c < 11; c++) begin
            redirect_valid = (c == 4);
            #1;
            if (c == 4) check("s3_redir_req", 32'(imem_req), 32'd0);
            if (c == 5 || c == 6) check("s3_flushed", 32'(id_valid), 32'd0);
            tick();
        end
        redirect_valid = 1'b0;
        drained("s3");

        // Redirect with two buffered words and no pop: only the head survives.
        reset_dut("rst3");
        redirect_pc = 32'h3200;
        push_seq(32'h3000, 2);
        push_seq(32'h3200, 4);
        exp_req = '{32'h3000, 32'h3004, 32'h3008, 32'h3200, 32'h3204};
        for (int c = 0; c < 11; c++) begin
            id_ready = (c == 2 || c >= 5);
            redirect_valid = (c == 4);
            #1;
            if (c == 4) check("s4_head", id_pc, 32'h3004);
            if (c == 6) check("s4_empty_valid", 32'(id_valid), 32'd0);
            if (c == 6) check("s4_hold_pc", id_pc, 32'h3004);
            tick();
        end
        redirect_valid = 1'b0;
        drained("s4");

        // Grant stalled, nothing in flight: slot fetched first, then the target.
        reset_dut("rst4");
        id_ready = 1'b1;
        redirect_pc = 32'h3400;
        push_seq(32'h3000, 4);
        exp_q.push_back(32'h3010);
        push_seq(32'h3400, 3);
        exp_req = '{32'h3000, 32'h3004, 32'h3008, 32'h300C, 32'h3010, 32'h3400, 32'h3404};
        for (int c = 0; c < 13; c++) begin
            imem_gnt = !(c == 4 || c == 5);
            redirect_valid = (c == 6);
            #1;
            if (c == 6) check("s5_redir_req", 32'(imem_req), 32'd0);
            if (c == 7) check("s5_slot_addr", imem_addr, 32'h3010);
            tick();
        end
        redirect_valid = 1'b0;
        drained("s5");

        // Reset mid-stream with two requests outstanding.
        reset_dut("rst5");
        id_ready = 1'b1;
        push_seq(32'h3000, 2);
        for (int c = 0; c < 4; c++) begin
            resp_en = (c < 2);
            tick();
        end
        #1;
        check("s6_pre_valid", 32'(id_valid), 32'd0);
        check("s6_pre_hold", id_pc, 32'h3004);
        check("s6_pre_sb", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        reset_dut("s6_midrst");
        id_ready = 1'b1;
        push_seq(32'h3000, 3);
        exp_req = '{32'h3000, 32'h3004};
        for (int c = 0; c < 5; c++) tick();
        drained("s6");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
